piso_tx: RTL and testbench

Parallel-in/serial-out byte transmitter, the transmit-side counterpart of the decoder-path SIPO. It accepts 8-bit words over a valid/ready handshake and buffers them in a small FIFO. Each word is serialized MSB-first onto a 1-bit stream with its own valid/ready handshake. It sits between byte-oriented sources (test vector memory, host interface) and the bit-serial convolutional encoder / channel input. A SIPO on the far end reassembles bytes bit-identical to those pushed here.

---
 rtl/piso_tx.sv | 135 +++++++++++++
 tb/tb_piso_tx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in/serial-out byte transmitter: a small word FIFO in front of an
// MSB-first shifter, valid/ready on both the parallel and the serial side.
module piso_tx #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_parallel_i,
    input  logic         valid_parallel_i,
    output logic         ready_parallel_o,
    output logic         data_serial_o,
    output logic         valid_serial_o,
    input  logic         ready_serial_i,
    output logic         byte_done_o,
    output logic         busy_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic [AW:0]    w_count_nxt;
    logic [W-1:0]   r_shift;
    logic [CW-1:0]  r_bit_cnt;
    logic           r_ready;
    logic           r_done;
    logic           w_push;
    logic           w_pop;
    logic           w_xfer;
    logic           w_last;
    logic           w_fifo_ne;

    assign w_push    = valid_parallel_i && r_ready;
    assign w_fifo_ne = (r_count != '0);
    assign w_xfer    = (r_state == S_SHIFT) && ready_serial_i;
    assign w_last    = w_xfer && (r_bit_cnt == CW'(W - 1));

    // A finished word is replaced at the same edge when one is queued,
    // so back-to-back words leave no idle bit between them.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fifo_ne) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    if (w_fifo_ne) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_parallel_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < (AW + 1)'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_bit_cnt <= '0;
            end else if (w_xfer) begin
                r_shift   <= {r_shift[W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + CW'(1);
            end
            r_done <= w_last;
        end
    end

    assign ready_parallel_o = r_ready;
    assign data_serial_o    = r_shift[W-1];
    assign valid_serial_o   = (r_state == S_SHIFT);
    assign byte_done_o      = r_done;
    assign busy_o           = valid_serial_o || w_fifo_ne;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: word-queue reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized stream.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       vin;
    logic       rdy_p;
    logic       dser;
    logic       vser;
    logic       rdy_s;
    logic       done;
    logic       busy;

    piso_tx #(.W(8), .DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .data_parallel_i  (din),
        .valid_parallel_i (vin),
        .ready_parallel_o (rdy_p),
        .data_serial_o    (dser),
        .valid_serial_o   (vser),
        .ready_serial_i   (rdy_s),
        .byte_done_o      (done),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: words in flight, bits already sent of the head word.
    logic [7:0] m_q[$];
    int         m_bit = 0;
    bit         m_valid = 0;
    bit         p_push = 0;
    bit         p_xfer = 0;
    logic [7:0] p_word;
    int         since_rel = 0;
    int         cyc = 0;
    int         push_cyc = 0;
    int         done_cnt = 0;
    logic [7:0] rx_bytes[$];
    int         rx_cyc[$];
    logic [7:0] rx_sr = 8'h00;
    int         rx_n = 0;

    always @(negedge clk) begin
        bit         nv;
        bit         e_done;
        int         fw;
        logic [7:0] hw;
        cyc++;
        if (rst) begin
            m_q.delete();
            m_bit     = 0;
            m_valid   = 0;
            p_push    = 0;
            p_xfer    = 0;
            since_rel = 0;
            rx_n      = 0;
            chk("rst_valid", vser, 0);
            chk("rst_data", dser, 0);
            chk("rst_ready", rdy_p, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
        end else begin
            e_done = 0;
            if (p_xfer && m_q.size() > 0) begin
                if (m_bit == 7) begin
                    e_done = 1;
                    nv = (m_q.size() > 1);
                    void'(m_q.pop_front());
                    m_bit = 0;
                end else begin
                    nv = 1;
                    m_bit++;
                end
            end else begin
                nv = m_valid ? 1'b1 : (m_q.size() > 0);
            end
            if (p_push) m_q.push_back(p_word);
            m_valid = nv;
            fw = m_q.size() - (m_valid ? 1 : 0);
            chk("m_valid", vser, m_valid);
            if (m_valid && m_q.size() > 0) begin
                hw = m_q[0];
                chk("m_data", dser, hw[7-m_bit]);
            end
            chk("m_done", done, e_done);
            chk("m_busy", busy, m_q.size() > 0);
            chk("m_ready", rdy_p, (since_rel > 0) && (fw < 2));
            if (done) done_cnt++;
            since_rel++;
            p_push = vin && rdy_p;
            p_word = din;
            p_xfer = vser && rdy_s;
            if (p_push) push_cyc = cyc;
            if (p_xfer) begin
                rx_cyc.push_back(cyc);
                rx_sr = {rx_sr[6:0], dser};
                rx_n++;
                if (rx_n == 8) begin
                    rx_bytes.push_back(rx_sr);
                    rx_n = 0;
                end
            end
        end
    end

    // All drivers run at posedge + 1.
    task automatic push(input logic [7:0] w);
        int n = 0;
        din = w;
        vin = 1'b1;
        @(negedge clk);
        while (!rdy_p && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    task automatic wait_bits(input int target);
        int n = 0;
        while (rx_cyc.size() < target && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) chk("bit_wait_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 4000);
        if (n >= 4000) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sent_q[$];
    bit         stop;

    initial begin
        int         b;
        int         bb;
        int         d0;
        int         n;
        logic [7:0] w;
        rst   = 1'b1;
        din   = 8'h00;
        vin   = 1'b0;
        rdy_s = 1'b0;
        #1;
        chk("por_valid", vser, 0);
        chk("por_ready", rdy_p, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", rdy_p, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", rdy_p, 1);

        // single word
        rdy_s = 1'b1;
        b = rx_bytes.size(); bb = rx_cyc.size(); d0 = done_cnt;
        push(8'hA5);
        wait_idle();
        chk("a5_byte", rx_bytes[b], 8'hA5);
        chk("a5_latency", rx_cyc[bb] - push_cyc, 2);
        chk("a5_contig", rx_cyc[bb+7] - rx_cyc[bb], 7);
        chk("a5_done", done_cnt - d0, 1);
        chk("a5_idle_valid", vser, 0);

        // back-to-back stream
        b = rx_bytes.size(); bb = rx_cyc.size(); d0 = done_cnt;
        push(8'h3C);
        push(8'hC3);
        push(8'hFF);
        wait_idle();
        chk("s_byte0", rx_bytes[b], 8'h3C);
        chk("s_byte1", rx_bytes[b+1], 8'hC3);
        chk("s_byte2", rx_bytes[b+2], 8'hFF);
        chk("s_contig", rx_cyc[bb+23] - rx_cyc[bb], 23);
        chk("s_done", done_cnt - d0, 3);

        // stall mid-word while bit 3 is presented
        b = rx_bytes.size(); bb = rx_cyc.size();
        push(8'h96);
        wait_bits(bb + 3);
        rdy_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", dser, 1);
            chk("stall_valid", vser, 1);
        end
        @(posedge clk);
        #1;
        rdy_s = 1'b1;
        wait_idle();
        chk("stall_byte", rx_bytes[b], 8'h96);

        // fill FIFO while serial side is blocked
        rdy_s = 1'b0;
        b = rx_bytes.size(); bb = rx_cyc.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        din = 8'h44;
        vin = 1'b1;
        @(negedge clk);
        chk("full_ready", rdy_p, 0);
        repeat (3) @(posedge clk);
        #1;
        rdy_s = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy_p && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("push44_timeout", 0, 1);
        @(posedge clk);
        #1;
        vin = 1'b0;
        wait_idle();
        chk("f_byte0", rx_bytes[b], 8'h11);
        chk("f_byte1", rx_bytes[b+1], 8'h22);
        chk("f_byte2", rx_bytes[b+2], 8'h33);
        chk("f_byte3", rx_bytes[b+3], 8'h44);
        chk("f_accept44", push_cyc - rx_cyc[bb+7], 1);

        // reset mid-word with a word queued
        bb = rx_cyc.size();
        push(8'h96);
        push(8'h5A);
        wait_bits(bb + 4);
        d0 = done_cnt;
        b = rx_bytes.size();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", vser, 0);
        chk("mid_rst_data", dser, 0);
        chk("mid_rst_ready", rdy_p, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);
        push(8'h01);
        wait_idle();
        chk("rst_nbytes", rx_bytes.size() - b, 1);
        chk("rst_byte", rx_bytes[b], 8'h01);
        chk("rst_done_after", done_cnt - d0, 1);

        // randomized stream
        b = rx_bytes.size(); d0 = done_cnt;
        stop = 0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    w = 8'($urandom);
                    sent_q.push_back(w);
                    push(w);
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    rdy_s = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rdy_s = 1'b1;
        wait_idle();
        chk("rand_nbytes", rx_bytes.size() - b, 256);
        for (int i = 0; i < 256 && b + i < rx_bytes.size(); i++) begin
            chk("rand_byte", rx_bytes[b+i], sent_q[i]);
        end
        chk("rand_done", done_cnt - d0, 256);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
